// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - issue-stage handshake, output and writeback bundle
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [5:0]  out_fn;
  logic [4:0]  out_rc;
  logic        wb_en;
  logic [4:0]  wb_rc;
  logic [31:0] wb_data;
  logic        illegal;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rc, wb_data,
    output in_ready, out_valid, out_a, out_b, out_fn, out_rc, illegal
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rc, wb_data,
    input  in_ready, out_valid, out_a, out_b, out_fn, out_rc, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode/issue stage with register file, scoreboard and bypass
module alu_issue (
  input logic       clk,
  input logic       rst_n,
  alu_issue_if.slave bus
);

  logic [31:0] regs [0:30];
  logic [30:0] pending;

  logic [5:0]  op;
  logic [4:0]  rc, ra, rb;
  logic        legal, is_const;
  logic [5:0]  fn;
  logic [31:0] opa, opb;
  logic [31:0] clr_mask, set_mask, live;
  logic        hazard, fire, issue;

  assign op = bus.in_instr[31:26];
  assign rc = bus.in_instr[25:21];
  assign ra = bus.in_instr[20:16];
  assign rb = bus.in_instr[15:11];
  assign is_const = op[4];

  // Opcode decode: low nibble selects the function, 0x2x register form, 0x3x constant form
  always_comb begin
    legal = op[5];
    fn    = 6'b000000;
    case (op[3:0])
      4'h0: fn = 6'b010000;
      4'h1: fn = 6'b010001;
      4'h4: fn = 6'b000011;
      4'h5: fn = 6'b000101;
      4'h6: fn = 6'b000111;
      4'h8: fn = 6'b101000;
      4'h9: fn = 6'b101100;
      4'hA: fn = 6'b100000;
      4'hC: fn = 6'b110000;
      4'hD: fn = 6'b110001;
      4'hE: fn = 6'b110011;
      default: legal = 1'b0;
    endcase
  end

  // Operand read: R31 is zero, a same-cycle writeback is forwarded ahead of the file
  always_comb begin
    opa = 32'd0;
    opb = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
    if (ra != 5'd31) begin
      if (bus.wb_en && bus.wb_rc == ra) opa = bus.wb_data;
      else                              opa = regs[ra];
    end
    if (!is_const) begin
      if (rb == 5'd31)                          opb = 32'd0;
      else if (bus.wb_en && bus.wb_rc == rb)    opb = bus.wb_data;
      else                                      opb = regs[rb];
    end
  end

  // Scoreboard view with this cycle's writeback already cleared; bit 31 is never pending
  always_comb begin
    clr_mask = 32'd0;
    if (bus.wb_en && bus.wb_rc != 5'd31) clr_mask = 32'd1 << bus.wb_rc;
    live   = {1'b0, pending} & ~clr_mask;
    hazard = live[ra] | (!is_const & live[rb]) | live[rc];
  end

  // Illegal words bypass the hazard check: they are dropped without touching state
  assign bus.in_ready = (!bus.out_valid | bus.out_ready) & (!legal | !hazard);
  assign fire  = bus.in_valid & bus.in_ready;
  assign issue = fire & legal;

  // Pending bit for the new destination; a same-cycle set overrides the clear
  always_comb begin
    set_mask = 32'd0;
    if (issue && rc != 5'd31) set_mask = 32'd1 << rc;
  end

  // Output register: load on issue, drop when consumed, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_a     <= 32'd0;
      bus.out_b     <= 32'd0;
      bus.out_fn    <= 6'd0;
      bus.out_rc    <= 5'd0;
      bus.illegal   <= 1'b0;
    end else begin
      bus.illegal <= fire & !legal;
      if (issue) begin
        bus.out_valid <= 1'b1;
        bus.out_a     <= opa;
        bus.out_b     <= opb;
        bus.out_fn    <= fn;
        bus.out_rc    <= rc;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  // Scoreboard update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 31'd0;
    else        pending <= (pending & ~clr_mask[30:0]) | set_mask[30:0];
  end

  // Register file writeback; writes to R31 are discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 31; i++) regs[i] <= 32'd0;
    end else if (bus.wb_en && bus.wb_rc != 5'd31) begin
      regs[bus.wb_rc] <= bus.wb_data;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  alu_issue_if bus();

  alu_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] mkc(input logic [5:0] op, input logic [4:0] rc, input logic [4:0] ra, input logic [15:0] lit);
    return {op, rc, ra, lit};
  endfunction

  function automatic logic [31:0] mkr(input logic [5:0] op, input logic [4:0] rc, input logic [4:0] ra, input logic [4:0] rb);
    return {op, rc, ra, rb, 11'd0};
  endfunction

  task automatic issue(input logic [31:0] w);
    bus.in_instr = w;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_rc = r; bus.wb_data = d;
    @(posedge clk); #1;
    bus.wb_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_a !== 32'd0 || bus.out_b !== 32'd0) $display("FAIL rst_ab: got %h/%h want 0/0", bus.out_a, bus.out_b); else pass_cnt++;
    total_cnt++; if (bus.out_fn !== 6'd0 || bus.out_rc !== 5'd0 || bus.illegal !== 1'b0) $display("FAIL rst_fn_rc_ill: got %b/%0d/%b want 0/0/0", bus.out_fn, bus.out_rc, bus.illegal); else pass_cnt++;
    total_cnt++; if (dut.pending !== 31'd0) $display("FAIL rst_pending: got %h want 0", dut.pending); else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addc;
    bus.out_ready = 1'b1;
    bus.in_instr = mkc(6'h30, 5'd1, 5'd31, 16'h0005);
    bus.in_valid = 1'b1;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL addc_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL addc_valid: got %b want 1", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_a !== 32'd0 || bus.out_b !== 32'd5) $display("FAIL addc_ab: got %h/%h want 0/5", bus.out_a, bus.out_b); else pass_cnt++;
    total_cnt++; if (bus.out_fn !== 6'b010000 || bus.out_rc !== 5'd1) $display("FAIL addc_fn_rc: got %b/%0d want 010000/1", bus.out_fn, bus.out_rc); else pass_cnt++;
    total_cnt++; if (dut.pending !== 31'h2) $display("FAIL addc_pending: got %h want 2", dut.pending); else pass_cnt++;
    wb_write(5'd1, 32'd5);
    total_cnt++; if (dut.pending !== 31'd0 || bus.out_valid !== 1'b0) $display("FAIL addc_wb: got pend %h valid %b want 0/0", dut.pending, bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_sign_ext;
    issue(mkc(6'h31, 5'd4, 5'd31, 16'hFFFE));
    total_cnt++; if (bus.out_b !== 32'hFFFF_FFFE) $display("FAIL sext_b: got %h want fffffffe", bus.out_b); else pass_cnt++;
    total_cnt++; if (bus.out_fn !== 6'b010001) $display("FAIL sext_fn: got %b want 010001", bus.out_fn); else pass_cnt++;
    wb_write(5'd4, 32'hFFFF_FFFE);
  endtask

  task automatic test_raw_bypass;
    issue(mkc(6'h30, 5'd2, 5'd31, 16'h0007));
    bus.in_instr = mkr(6'h20, 5'd3, 5'd2, 5'd2);
    bus.in_valid = 1'b1;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL raw_stall0: got %b want 0", bus.in_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL raw_stall1: got %b want 0", bus.in_ready); else pass_cnt++;
    bus.wb_en = 1'b1; bus.wb_rc = 5'd2; bus.wb_data = 32'h1234;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL raw_wb_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.wb_en = 1'b0;
    total_cnt++; if (bus.out_a !== 32'h1234 || bus.out_b !== 32'h1234) $display("FAIL raw_bypass: got %h/%h want 1234/1234", bus.out_a, bus.out_b); else pass_cnt++;
    total_cnt++; if (bus.out_rc !== 5'd3 || dut.pending !== 31'h8) $display("FAIL raw_pend: got rc %0d pend %h want 3/8", bus.out_rc, dut.pending); else pass_cnt++;
    wb_write(5'd3, 32'h2468);
    issue(mkr(6'h20, 5'd13, 5'd2, 5'd31));
    total_cnt++; if (bus.out_a !== 32'h1234 || bus.out_b !== 32'd0) $display("FAIL rf_read: got %h/%h want 1234/0", bus.out_a, bus.out_b); else pass_cnt++;
    wb_write(5'd13, 32'h1234);
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    issue(mkc(6'h30, 5'd5, 5'd31, 16'h0011));
    bus.in_instr = mkc(6'h30, 5'd6, 5'd31, 16'h0022);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) $display("FAIL bp_hold%0d: got ready %b valid %b want 0/1", i, bus.in_ready, bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.out_b !== 32'h11 || bus.out_rc !== 5'd5 || bus.out_fn !== 6'b010000) $display("FAIL bp_stable%0d: got %h/%0d/%b want 11/5/010000", i, bus.out_b, bus.out_rc, bus.out_fn); else pass_cnt++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", bus.in_ready); else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_b !== 32'h22 || bus.out_rc !== 5'd6) $display("FAIL bp_second: got %b/%h/%0d want 1/22/6", bus.out_valid, bus.out_b, bus.out_rc); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", bus.out_valid); else pass_cnt++;
    wb_write(5'd5, 32'h11);
    wb_write(5'd6, 32'h22);
  endtask

  task automatic test_opcode_sweep;
    logic [5:0] ops [11];
    logic [5:0] fns [11];
    ops = '{6'h20, 6'h21, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2A, 6'h2C, 6'h2D, 6'h2E};
    fns = '{6'b010000, 6'b010001, 6'b000011, 6'b000101, 6'b000111, 6'b101000,
            6'b101100, 6'b100000, 6'b110000, 6'b110001, 6'b110011};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 22; k++) begin
      logic [5:0] op;
      op = ops[k % 11] + ((k >= 11) ? 6'h10 : 6'h00);
      bus.in_instr = mkr(op, 5'd31, 5'd31, 5'd31);
      bus.in_valid = 1'b1;
      #1;
      if (bus.in_ready !== 1'b1) begin
        total_cnt++; $display("FAIL sweep_ready op %h: got %b want 1", op, bus.in_ready);
      end
      @(posedge clk); #1;
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_fn !== fns[k % 11]) $display("FAIL sweep op %h: got valid %b fn %b want 1 %b", op, bus.out_valid, bus.out_fn, fns[k % 11]); else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (dut.pending !== 31'd0) $display("FAIL sweep_pending: got %h want 0", dut.pending); else pass_cnt++;
  endtask

  task automatic test_illegal;
    bus.out_ready = 1'b1;
    issue(mkc(6'h30, 5'd9, 5'd31, 16'h0001));
    bus.in_instr = mkr(6'h00, 5'd9, 5'd9, 5'd9);
    bus.in_valid = 1'b1;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL ill_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    @(posedge clk); #1;
    bus.in_instr = mkr(6'h3F, 5'd0, 5'd0, 5'd0);
    total_cnt++; if (bus.illegal !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL ill_pulse1: got ill %b valid %b want 1/0", bus.illegal, bus.out_valid); else pass_cnt++;
    total_cnt++; if (dut.pending !== 31'h200) $display("FAIL ill_pending: got %h want 200", dut.pending); else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total_cnt++; if (bus.illegal !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL ill_pulse2: got ill %b valid %b want 1/0", bus.illegal, bus.out_valid); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.illegal !== 1'b0 || dut.pending !== 31'h200) $display("FAIL ill_end: got ill %b pend %h want 0/200", bus.illegal, dut.pending); else pass_cnt++;
    wb_write(5'd9, 32'd1);
  endtask

  task automatic test_r31;
    bus.out_ready = 1'b1;
    bus.wb_en = 1'b1; bus.wb_rc = 5'd31; bus.wb_data = 32'hDEAD_BEEF;
    issue(mkr(6'h20, 5'd31, 5'd31, 5'd31));
    bus.wb_en = 1'b0;
    total_cnt++; if (bus.out_a !== 32'd0 || bus.out_b !== 32'd0 || bus.out_rc !== 5'd31) $display("FAIL r31_ops: got %h/%h/%0d want 0/0/31", bus.out_a, bus.out_b, bus.out_rc); else pass_cnt++;
    total_cnt++; if (dut.pending !== 31'd0) $display("FAIL r31_pending: got %h want 0", dut.pending); else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    issue(mkc(6'h30, 5'd10, 5'd31, 16'h0003));
    bus.in_instr = mkr(6'h20, 5'd11, 5'd10, 5'd10);
    bus.in_valid = 1'b1;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) $display("FAIL rstm_stall: got ready %b valid %b want 0/1", bus.in_ready, bus.out_valid); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0 || dut.pending !== 31'd0) $display("FAIL rstm_clear: got valid %b pend %h want 0/0", bus.out_valid, dut.pending); else pass_cnt++;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    issue(mkr(6'h20, 5'd12, 5'd2, 5'd31));
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_a !== 32'd0) $display("FAIL rstm_rf: got valid %b a %h want 1/0", bus.out_valid, bus.out_a); else pass_cnt++;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.out_ready = 1'b0;
    bus.wb_en = 1'b0; bus.wb_rc = 5'd0; bus.wb_data = 32'd0;
    test_reset();
    test_addc();
    test_sign_ext();
    test_raw_bypass();
    test_backpressure();
    test_opcode_sweep();
    test_illegal();
    test_r31();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
